regfile_2r1w: RTL and testbench
===============================

// Module: regfile_2r1w
// PURPOSE
//  Parametrised register file for the datapath: DEPTH words of DATA_W bits.
//  Two independent registered read ports, one write port, synchronous reset.
//  Read data is full DATA_W; no truncation.
//  Feeds ALU operand A/B from read ports 0/1; the write port takes the result.
// PARAMETERS
//  DATA_W     16  word width in bits
//  ADDR_W      3  address width; DEPTH = 2**ADDR_W words
//  ZERO_REG    0  1: word 0 reads as 0 and ignores writes; 0: word 0 is ordinary
// PORTS
//  clk        in   1        single clock, all state changes on posedge
//  rst        in   1        synchronous reset, active-high
//  wr_en      in   1        write strobe
//  wr_addr    in   ADDR_W   write address
//  wr_data    in   DATA_W   write data
//  rd0_en     in   1        read request, port 0
//  rd0_addr   in   ADDR_W   read address, port 0
//  rd0_data   out  DATA_W   read data, port 0 (registered)
//  rd0_valid  out  1        rd0_data valid this cycle
//  rd1_en     in   1        read request, port 1
//  rd1_addr   in   ADDR_W   read address, port 1
//  rd1_data   out  DATA_W   read data, port 1 (registered)
//  rd1_valid  out  1        rd1_data valid this cycle
// BEHAVIOUR
//  - Clock is clk; reset is synchronous and active-high on rst. rst is sampled
//    on posedge clk only.
//  - Reset: all DEPTH words <= 0; rd0_data/rd1_data <= 0; rd0_valid/rd1_valid <= 0.
//  - Reset priority: rst overrides wr_en/rdN_en in the same cycle. The write is
//    dropped and no valid is produced. Reset mid-stream is legal.
//  - Write: wr_en=1 at posedge N; mem[wr_addr] <= wr_data, visible to reads
//    sampled at posedge N+1.
//  - Read latency: exactly 1 cycle.
//      rdN_en=1 at posedge N -> after posedge N: rdN_data = mem[rdN_addr], rdN_valid=1.
//  - rdN_en=0 at posedge N -> rdN_valid=0 after N; rdN_data holds its previous
//    value (no toggling).
//  - rdN_valid is a 1-cycle pulse per request; back-to-back requests give
//    continuous valid.
//  - Both ports are fully independent. The same address on both ports is legal,
//    and both ports return identical data.
//  - Same-cycle write + read, same address: behaviour set by REGFILE_BYPASS_EN
//    (see CONFIGURATION). Different addresses never interact.
//  - ZERO_REG=1: writes to address 0 are discarded; reads of address 0 return 0
//    (bypass also returns 0).
//  - No handshake back-pressure: every request is served. No FSM beyond the
//    per-port valid flag.
// CONFIGURATION
//  - REGFILE_BYPASS_EN defined: write-to-read forwarding. If wr_en=1 and
//    wr_addr==rdN_addr with rdN_en=1 in the same cycle, rdN_data <= wr_data
//    (new value), on both ports independently.
//  - REGFILE_BYPASS_EN undefined: read-before-write. rdN_data <= old
//    mem[rdN_addr]; the new value is seen from the next read onward.
//  - Reset priority and ZERO_REG rules apply identically in both builds.
// TESTING
//  1. Reset: preload via writes, assert rst 1 cycle -> both valids 0, both data 0,
//     and reads of all 8 words return 0x0000.
//  2. Write 0x1234 @3, then next cycle rd0 @3 and rd1 @3 -> one cycle later both
//     ports read 0x1234 with valid=1.
//  3. Same-cycle write 0xBEEF @5 and rd0 @5 (mem[5]=0x0001):
//     - BYPASS_EN build: rd0_data=0xBEEF.
//     - Otherwise: rd0_data=0x0001, and the following read gives 0xBEEF.
//  4. Streaming: rd0_en high for 8 cycles, addr 0..7 -> valid high for 8
//     consecutive cycles; data in order.
//     Drop rd0_en -> valid=0 and data holds the word 7 value.
//  5. rst asserted with wr_en=1 (0xAAAA @2) and rd1_en=1 -> mem[2]=0 and
//     rd1_valid=0 next cycle.
//  6. ZERO_REG=1: write 0xFFFF @0, read @0 on both ports -> 0x0000, valid=1;
//     write @1 is unaffected.

Source files
------------

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with registered read ports, synchronous reset
// and optional hard-wired zero word. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_2r1w #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd0_en,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic              rd0_valid,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd1_valid
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd0_data_r;
    logic [DATA_W-1:0] rd1_data_r;
    logic              rd0_valid_r;
    logic              rd1_valid_r;
    logic [DATA_W-1:0] rd0_next_s;
    logic [DATA_W-1:0] rd1_next_s;
    logic              wr_ok_s;

    // Write qualification: word 0 is read-only when it is the hard-wired zero.
    always_comb begin
        wr_ok_s = wr_en;
        if ((ZERO_REG != 32'sd0) && (wr_addr == {ADDR_W{1'b0}})) begin
            wr_ok_s = 1'b0;
        end else begin
            wr_ok_s = wr_en;
        end
    end

    // Read-port next data; the zero word wins over forwarding.
    always_comb begin
        rd0_next_s = mem_r[rd0_addr];
        rd1_next_s = mem_r[rd1_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == rd0_addr)) begin
            rd0_next_s = wr_data;
        end else begin
            rd0_next_s = mem_r[rd0_addr];
        end
        if (wr_en && (wr_addr == rd1_addr)) begin
            rd1_next_s = wr_data;
        end else begin
            rd1_next_s = mem_r[rd1_addr];
        end
`endif
        if ((ZERO_REG != 32'sd0) && (rd0_addr == {ADDR_W{1'b0}})) begin
            rd0_next_s = {DATA_W{1'b0}};
        end else begin
            rd0_next_s = rd0_next_s;
        end
        if ((ZERO_REG != 32'sd0) && (rd1_addr == {ADDR_W{1'b0}})) begin
            rd1_next_s = {DATA_W{1'b0}};
        end else begin
            rd1_next_s = rd1_next_s;
        end
    end

    // Storage array update; reset clears every word and drops a coincident write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end else begin
            mem_r[wr_addr] <= mem_r[wr_addr];
        end
    end

    // Read port 0: valid pulses per request, data holds between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd0_data_r  <= {DATA_W{1'b0}};
            rd0_valid_r <= 1'b0;
        end else if (rd0_en) begin
            rd0_data_r  <= rd0_next_s;
            rd0_valid_r <= 1'b1;
        end else begin
            rd0_data_r  <= rd0_data_r;
            rd0_valid_r <= 1'b0;
        end
    end

    // Read port 1: identical behaviour, fully independent of port 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_data_r  <= {DATA_W{1'b0}};
            rd1_valid_r <= 1'b0;
        end else if (rd1_en) begin
            rd1_data_r  <= rd1_next_s;
            rd1_valid_r <= 1'b1;
        end else begin
            rd1_data_r  <= rd1_data_r;
            rd1_valid_r <= 1'b0;
        end
    end

    assign rd0_data  = rd0_data_r;
    assign rd0_valid = rd0_valid_r;
    assign rd1_data  = rd1_data_r;
    assign rd1_valid = rd1_valid_r;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: an ordinary instance and a ZERO_REG=1 instance share stimulus;
// each is compared every cycle against an array model, plus directed constant checks.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd0_en;
    logic [2:0]  rd0_addr;
    logic        rd1_en;
    logic [2:0]  rd1_addr;

    logic [15:0] od [2][2];
    logic        ov [2][2];

    logic [15:0] mm [2][8];
    logic [15:0] ed [2][2];
    logic        ev [2][2];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut_plain (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(od[0][0]), .rd0_valid(ov[0][0]),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(od[0][1]), .rd1_valid(ov[0][1])
    );

    regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut_zero (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(od[1][0]), .rd0_valid(ov[1][0]),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(od[1][1]), .rd1_valid(ov[1][1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // What a read of address a returns this cycle, judged from the rules alone.
    function automatic logic [15:0] mread(input int i, input logic [2:0] a);
        if (i == 1 && a == 3'd0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return mm[i][a];
    endfunction

    task automatic set_in(input logic r, input logic we, input logic [2:0] wa, input logic [15:0] wd,
                          input logic e0, input logic [2:0] a0, input logic e1, input logic [2:0] a1);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        rd0_en = e0; rd0_addr = a0; rd1_en = e1; rd1_addr = a1;
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int k = 0; k < 8; k++) mm[i][k] = 16'h0000;
                for (int p = 0; p < 2; p++) begin ed[i][p] = 16'h0000; ev[i][p] = 1'b0; end
            end else begin
                if (rd0_en) begin ed[i][0] = mread(i, rd0_addr); ev[i][0] = 1'b1; end
                else ev[i][0] = 1'b0;
                if (rd1_en) begin ed[i][1] = mread(i, rd1_addr); ev[i][1] = 1'b1; end
                else ev[i][1] = 1'b0;
                if (wr_en && !(i == 1 && wr_addr == 3'd0)) mm[i][wr_addr] = wr_data;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("model_d%0d_p%0d", i, p), {16'h0000, od[i][p]}, {16'h0000, ed[i][p]});
                chk($sformatf("model_v%0d_p%0d", i, p), {31'd0, ov[i][p]}, {31'd0, ev[i][p]});
            end
        end
    endtask

    initial begin
        set_in(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle();

        // 1: preload, reset, then every word reads back zero
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 1'b1, 3'(i), 16'(i + 16'h0011), 1'b0, 3'd0, 1'b0, 3'd0);
            cycle();
        end
        set_in(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle();
        chk("t1_v0", {31'd0, ov[0][0]}, 32'd0);
        chk("t1_v1", {31'd0, ov[0][1]}, 32'd0);
        chk("t1_d0", {16'h0000, od[0][0]}, 32'd0);
        chk("t1_d1", {16'h0000, od[0][1]}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'(i), 1'b1, 3'(7 - i));
            cycle();
            chk("t1_rd0", {16'h0000, od[0][0]}, 32'd0);
            chk("t1_rd1", {16'h0000, od[0][1]}, 32'd0);
        end

        // 2: write then read the same word on both ports
        set_in(1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle();
        set_in(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 1'b1, 3'd3);
        cycle();
        chk("t2_rd0", {16'h0000, od[0][0]}, 32'h0000_1234);
        chk("t2_rd1", {16'h0000, od[0][1]}, 32'h0000_1234);
        chk("t2_v0", {31'd0, ov[0][0]}, 32'd1);
        chk("t2_v1", {31'd0, ov[0][1]}, 32'd1);

        // 3: same-cycle write and read of one address
        set_in(1'b0, 1'b1, 3'd5, 16'h0001, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle();
        set_in(1'b0, 1'b1, 3'd5, 16'hBEEF, 1'b1, 3'd5, 1'b0, 3'd0);
        cycle();
`ifdef REGFILE_BYPASS_EN
        chk("t3_same", {16'h0000, od[0][0]}, 32'h0000_BEEF);
`else
        chk("t3_same", {16'h0000, od[0][0]}, 32'h0000_0001);
`endif
        set_in(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 1'b0, 3'd0);
        cycle();
        chk("t3_next", {16'h0000, od[0][0]}, 32'h0000_BEEF);

        // 4: streaming reads of all words, then hold
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 1'b1, 3'(i), 16'(16'h0100 + i), 1'b0, 3'd0, 1'b0, 3'd0);
            cycle();
        end
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'(i), 1'b0, 3'd0);
            cycle();
            chk("t4_v", {31'd0, ov[0][0]}, 32'd1);
            chk("t4_d", {16'h0000, od[0][0]}, 32'(16'h0100 + i));
        end
        set_in(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle();
        chk("t4_drop_v", {31'd0, ov[0][0]}, 32'd0);
        chk("t4_hold_d", {16'h0000, od[0][0]}, 32'h0000_0107);
        cycle();
        chk("t4_hold_d2", {16'h0000, od[0][0]}, 32'h0000_0107);

        // 5: reset beats a coincident write and read
        set_in(1'b1, 1'b1, 3'd2, 16'hAAAA, 1'b0, 3'd0, 1'b1, 3'd2);
        cycle();
        chk("t5_v1", {31'd0, ov[0][1]}, 32'd0);
        set_in(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 3'd2);
        cycle();
        chk("t5_mem2", {16'h0000, od[0][1]}, 32'd0);

        // 6: hard-wired zero word
        set_in(1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle();
        set_in(1'b0, 1'b1, 3'd1, 16'h5555, 1'b1, 3'd0, 1'b1, 3'd0);
        cycle();
        chk("t6_z_rd0", {16'h0000, od[1][0]}, 32'd0);
        chk("t6_z_rd1", {16'h0000, od[1][1]}, 32'd0);
        chk("t6_z_v0", {31'd0, ov[1][0]}, 32'd1);
        chk("t6_plain0", {16'h0000, od[0][0]}, 32'h0000_FFFF);
        set_in(1'b0, 1'b1, 3'd0, 16'h7777, 1'b1, 3'd1, 1'b1, 3'd0);
        cycle();
        chk("t6_z_w1", {16'h0000, od[1][0]}, 32'h0000_5555);
        chk("t6_z_byp0", {16'h0000, od[1][1]}, 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            set_in(($urandom_range(31) == 0), 1'($urandom), 3'($urandom), 16'($urandom),
                   1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
